// File: rtl/serial_rx_8_if.sv
// rtl/serial_rx_8_if.sv - serial line and received-byte signals for the 8N1 receiver
interface serial_rx_8_if;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    modport master (
        output rx,
        input  data_out,
        input  data_valid,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  rx,
        output data_out,
        output data_valid,
        output frame_err,
        output busy
    );
endinterface

// File: rtl/serial_rx_8.sv
// rtl/serial_rx_8.sv - 8N1 serial receiver, LSB first, mid-bit sampling
module serial_rx_8 #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_rx_8_if.slave  dif
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    idx_q;
    logic [7:0]    shift_q;
    logic [7:0]    data_q;
    logic          valid_q;
    logic          ferr_q;
    logic          sync1_q;
    logic          rx_s_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= dif.rx;
            rx_s_q  <= sync1_q;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (!rx_s_q) state_q <= START;
                end
                // Half a bit after the falling edge: still low means a real start bit.
                START: begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        state_q <= rx_s_q ? IDLE : DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q          <= '0;
                        shift_q[idx_q] <= rx_s_q;
                        if (idx_q == 3'd7) state_q <= STOP;
                        else               idx_q   <= idx_q + 3'd1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                        if (rx_s_q) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                        end else begin
                            ferr_q  <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dif.data_out   = data_q;
    assign dif.data_valid = valid_q;
    assign dif.frame_err  = ferr_q;
    assign dif.busy       = (state_q != IDLE);
endmodule
